// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register with a
// valid/ready handshake, 2-entry skid buffer, flush and perf counters.
module pipe_stage_reg #(
    parameter int DATA_W = 16,
    parameter int LANES  = 2,
    parameter int CTRL_W = 4,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   in_data,
    input  logic [CTRL_W-1:0]         in_ctrl,
    input  logic [ADDR_W-1:0]         in_waddr,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*DATA_W-1:0]   out_data,
    output logic [CTRL_W-1:0]         out_ctrl,
    output logic [ADDR_W-1:0]         out_waddr,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic [CNT_W-1:0]          bubble_cnt
);

    localparam int BUS_W = LANES * DATA_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state;
    state_t             stateNext;

    logic [BUS_W-1:0]   mainData;
    logic [CTRL_W-1:0]  mainCtrl;
    logic [ADDR_W-1:0]  mainWaddr;

    logic [BUS_W-1:0]   skidData;
    logic [CTRL_W-1:0]  skidCtrl;
    logic [ADDR_W-1:0]  skidWaddr;

    logic               accept;
    logic               pop;
    logic               loadMainIn;
    logic               loadMainSkid;
    logic               loadSkid;
    logic               stallHit;
    logic               bubbleHit;

    logic [CNT_W-1:0]   stallCnt;
    logic [CNT_W-1:0]   bubbleCnt;

    // Ready only depends on occupancy, so no comb path from out_ready.
    assign in_ready  = rst & (state != FULL);
    assign out_valid = (state != EMPTY);

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    assign stallHit  = out_valid & ~out_ready;
    assign bubbleHit = ~out_valid;

    // Next-state and register load selects; flush wins over any handshake.
    always_comb begin
        stateNext    = state;
        loadMainIn   = 1'b0;
        loadMainSkid = 1'b0;
        loadSkid     = 1'b0;
        if (flush) begin
            stateNext = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        stateNext  = ONE;
                        loadMainIn = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        loadMainIn = 1'b1;
                    end else if (accept) begin
                        stateNext = FULL;
                        loadSkid  = 1'b1;
                    end else if (pop) begin
                        stateNext = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        stateNext    = ONE;
                        loadMainSkid = 1'b1;
                    end
                end
                default: begin
                    stateNext = EMPTY;
                end
            endcase
        end
    end

    // Occupancy state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= EMPTY;
        end else begin
            state <= stateNext;
        end
    end

    // Main register feeds the outputs; it keeps its value across a flush.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mainData  <= '0;
            mainCtrl  <= '0;
            mainWaddr <= '0;
        end else if (loadMainIn) begin
            mainData  <= in_data;
            mainCtrl  <= in_ctrl;
            mainWaddr <= in_waddr;
        end else if (loadMainSkid) begin
            mainData  <= skidData;
            mainCtrl  <= skidCtrl;
            mainWaddr <= skidWaddr;
        end
    end

    // Skid register catches the entry accepted while main is stalled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            skidData  <= '0;
            skidCtrl  <= '0;
            skidWaddr <= '0;
        end else if (loadSkid) begin
            skidData  <= in_data;
            skidCtrl  <= in_ctrl;
            skidWaddr <= in_waddr;
        end
    end

    // Saturating counters, qualified by the state before this edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stallCnt  <= '0;
            bubbleCnt <= '0;
        end else begin
            if (stallHit && (stallCnt != {CNT_W{1'b1}})) begin
                stallCnt <= stallCnt + CNT_W'(1);
            end
            if (bubbleHit && (bubbleCnt != {CNT_W{1'b1}})) begin
                bubbleCnt <= bubbleCnt + CNT_W'(1);
            end
        end
    end

    // Bubbles carry no control so downstream never sees a stray write.
    assign out_ctrl   = out_valid ? mainCtrl : '0;
    assign out_data   = mainData;
    assign out_waddr  = mainWaddr;
    assign stall_cnt  = stallCnt;
    assign bubble_cnt = bubbleCnt;

endmodule
